// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the external memory bus controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
`timescale 1ns/1ps
package cpu_bus_pkg;

  // Default width of the multiplexed address/data bus.
  localparam int BITS = 8;

  // rom_ram select encoding on the external bus.
  localparam logic FETCH_ROM = 1'b0;
  localparam logic FETCH_RAM = 1'b1;

  // Bus sequencer states.
  typedef enum logic [2:0] {
    STATE_IDLE = 3'd0,
    STATE_ADDR = 3'd1,
    STATE_WAIT = 3'd2,
    STATE_DATA = 3'd3,
    STATE_DONE = 3'd4
  } state_t;

  // Which requester owns the bus. GRANT_NONE only appears while idle.
  typedef enum logic [1:0] {
    GRANT_NONE  = 2'd0,
    GRANT_FETCH = 2'd1,
    GRANT_MEM   = 2'd2
  } grant_t;

endpackage

// File: rtl/bus_arbiter.sv
// Grant decision between the instruction fetcher and the load/store path.
// Latency: combinational grant while enable is high; round-robin history updates on the grant edge.
// Backpressure: requests are levels; a loser simply stays pending until the next enabled cycle.
//
// Ports: clk, reset (async active-low, only used by the round-robin history flop),
//        enable (controller is idle), fetch_req, mem_req -> grant_valid, grant_sel.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin; otherwise mem has fixed priority.
`timescale 1ns/1ps
module bus_arbiter
  import cpu_bus_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   enable,
  input  logic   fetch_req,
  input  logic   mem_req,
  output logic   grant_valid,
  output grant_t grant_sel
);

  assign grant_valid = enable && (fetch_req || mem_req);

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers the last winner so a tie goes to the other requester.
  grant_t last_grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= GRANT_FETCH;
    end else if (grant_valid) begin
      last_grant <= grant_sel;
    end
  end

  always_comb begin
    grant_sel = GRANT_NONE;
    if (fetch_req && mem_req) begin
      if (last_grant == GRANT_FETCH) begin
        grant_sel = GRANT_MEM;
      end else begin
        grant_sel = GRANT_FETCH;
      end
    end else if (mem_req) begin
      grant_sel = GRANT_MEM;
    end else if (fetch_req) begin
      grant_sel = GRANT_FETCH;
    end
  end
`else
  // Fixed priority has no state, so clock and reset are deliberately unused here.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ reset;

  always_comb begin
    grant_sel = GRANT_NONE;
    if (mem_req) begin
      grant_sel = GRANT_MEM;
    end else if (fetch_req) begin
      grant_sel = GRANT_FETCH;
    end
  end
`endif

endmodule

// File: rtl/mem_bus_ctrl.sv
// Sequencer for the shared multiplexed external memory bus (fetch port + load/store port).
// Latency: req seen in IDLE at cycle N -> ack pulse at N+3+WAIT_CYCLES; one transaction per 4+WAIT_CYCLES cycles.
// Backpressure: req is a level held until ack; an ungranted requester waits for the next IDLE.
//
// Ports: clk, reset (async active-low);
//        fetch_req/fetch_rom_ram/fetch_addr -> fetch_ack/fetch_data;
//        mem_req/mem_we/mem_rom_ram/mem_addr/mem_wdata -> mem_ack/mem_rdata;
//        bus_in -> bus_out/rom_ram/addr_data/bus_we (chip pins).
// Build option: ARB_ROUND_ROBIN_EN selects round-robin arbitration (see bus_arbiter).
`timescale 1ns/1ps
module mem_bus_ctrl #(
  parameter int BITS        = cpu_bus_pkg::BITS,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_req,
  input  logic            fetch_rom_ram,
  input  logic [BITS-1:0] fetch_addr,
  output logic            fetch_ack,
  output logic [BITS-1:0] fetch_data,
  input  logic            mem_req,
  input  logic            mem_we,
  input  logic            mem_rom_ram,
  input  logic [BITS-1:0] mem_addr,
  input  logic [BITS-1:0] mem_wdata,
  output logic            mem_ack,
  output logic [BITS-1:0] mem_rdata,
  input  logic [BITS-1:0] bus_in,
  output logic [BITS-1:0] bus_out,
  output logic            rom_ram,
  output logic            addr_data,
  output logic            bus_we
);
  import cpu_bus_pkg::*;

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

  state_t          state_q, state_d;
  grant_t          grant_q;
  logic [BITS-1:0] addr_q;
  logic [BITS-1:0] wdata_q;
  logic            rom_ram_q;
  logic            we_q;
  logic [2:0]      wait_cnt_q;

  logic            grant_valid;
  grant_t          grant_sel;

  bus_arbiter u_arb (
    .clk         (clk),
    .reset       (reset),
    .enable      (state_q == STATE_IDLE),
    .fetch_req   (fetch_req),
    .mem_req     (mem_req),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= STATE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pins depend only on state_q and latched fields, never on the live request inputs.
  always_comb begin
    state_d   = state_q;
    bus_out   = '0;
    rom_ram   = FETCH_ROM;
    addr_data = 1'b0;
    bus_we    = 1'b0;
    fetch_ack = 1'b0;
    mem_ack   = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        if (grant_valid) begin
          state_d = STATE_ADDR;
        end
      end
      STATE_ADDR: begin
        bus_out = addr_q;
        rom_ram = rom_ram_q;
        if (WAIT_CYCLES > 0) begin
          state_d = STATE_WAIT;
        end else begin
          state_d = STATE_DATA;
        end
      end
      STATE_WAIT: begin
        addr_data = 1'b1;
        rom_ram   = rom_ram_q;
        if (we_q) begin
          bus_out = wdata_q;
        end
        if (wait_cnt_q <= 3'd1) begin
          state_d = STATE_DATA;
        end
      end
      STATE_DATA: begin
        addr_data = 1'b1;
        rom_ram   = rom_ram_q;
        bus_we    = we_q;
        if (we_q) begin
          bus_out = wdata_q;
        end
        state_d = STATE_DONE;
      end
      STATE_DONE: begin
        fetch_ack = (grant_q == GRANT_FETCH);
        mem_ack   = (grant_q == GRANT_MEM);
        state_d   = STATE_IDLE;
      end
      default: begin
        state_d = STATE_IDLE;
      end
    endcase
  end

  // Transaction fields are captured once at grant so requesters may change inputs freely afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q    <= GRANT_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rom_ram_q  <= 1'b0;
      we_q       <= 1'b0;
      wait_cnt_q <= 3'd0;
      fetch_data <= '0;
      mem_rdata  <= '0;
    end else begin
      case (state_q)
        STATE_IDLE: begin
          if (grant_valid) begin
            grant_q <= grant_sel;
            if (grant_sel == GRANT_MEM) begin
              addr_q    <= mem_addr;
              wdata_q   <= mem_wdata;
              rom_ram_q <= mem_rom_ram;
              we_q      <= mem_we;
            end else begin
              // Fetches are always reads.
              addr_q    <= fetch_addr;
              wdata_q   <= '0;
              rom_ram_q <= fetch_rom_ram;
              we_q      <= 1'b0;
            end
          end
        end
        STATE_ADDR: begin
          wait_cnt_q <= WAIT_LOAD;
        end
        STATE_WAIT: begin
          if (wait_cnt_q != 3'd0) begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end
        STATE_DATA: begin
          if (!we_q) begin
            if (grant_q == GRANT_FETCH) begin
              fetch_data <= bus_in;
            end else begin
              mem_rdata <= bus_in;
            end
          end
        end
        STATE_DONE: begin
          grant_q <= GRANT_NONE;
        end
        default: begin
          grant_q <= GRANT_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
`timescale 1ns/1ps
module tb_mem_bus_ctrl;

  localparam int NI = 2;   // instance 0: WAIT_CYCLES=1, instance 1: WAIT_CYCLES=0

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic       fetch_req = 0, fetch_rom_ram = 0;
  logic [7:0] fetch_addr = 0;
  logic       mem_req = 0, mem_we = 0, mem_rom_ram = 0;
  logic [7:0] mem_addr = 0, mem_wdata = 0, bus_in = 0;

  logic       fetch_ack_o [NI];
  logic [7:0] fetch_data_o[NI];
  logic       mem_ack_o   [NI];
  logic [7:0] mem_rdata_o [NI];
  logic [7:0] bus_out_o   [NI];
  logic       rom_ram_o   [NI];
  logic       addr_data_o [NI];
  logic       bus_we_o    [NI];

  always #5 clk = ~clk;

  mem_bus_ctrl #(.BITS(8), .WAIT_CYCLES(1)) u_dut0 (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_rom_ram(fetch_rom_ram), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack_o[0]), .fetch_data(fetch_data_o[0]),
    .mem_req(mem_req), .mem_we(mem_we), .mem_rom_ram(mem_rom_ram), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack_o[0]), .mem_rdata(mem_rdata_o[0]),
    .bus_in(bus_in), .bus_out(bus_out_o[0]), .rom_ram(rom_ram_o[0]),
    .addr_data(addr_data_o[0]), .bus_we(bus_we_o[0])
  );

  mem_bus_ctrl #(.BITS(8), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_rom_ram(fetch_rom_ram), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack_o[1]), .fetch_data(fetch_data_o[1]),
    .mem_req(mem_req), .mem_we(mem_we), .mem_rom_ram(mem_rom_ram), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack_o[1]), .mem_rdata(mem_rdata_o[1]),
    .bus_in(bus_in), .bus_out(bus_out_o[1]), .rom_ram(rom_ram_o[1]),
    .addr_data(addr_data_o[1]), .bus_we(bus_we_o[1])
  );

  // Transaction-level reference: k counts cycles since the grant edge
  // (1 = address, 2..2+W = data-side phases ending in the data cycle, 3+W = ack).
  typedef struct {
    bit         busy;
    int         k;
    bit         g_mem;
    logic [7:0] addr;
    logic [7:0] wdata;
    bit         rr;
    bit         we;
    logic [7:0] fdata;
    logic [7:0] mdata;
    bit         last_mem;
  } mdl_t;

  mdl_t m[NI];
  bit   exp_fack[NI];
  bit   exp_mack[NI];
  bit   ack_log[$];   // instance 0 ack order: 0 = fetch, 1 = mem
  int   dut_acks0 = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int wc(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m[i] = '{default: 0};
      exp_fack[i] = 0;
      exp_mack[i] = 0;
    end
  endtask

  task automatic model_advance();
    if (!reset) return;
    for (int i = 0; i < NI; i++) begin
      int w;
      w = wc(i);
      if (m[i].busy) begin
        if (m[i].k == 2 + w && !m[i].we) begin
          if (m[i].g_mem) m[i].mdata = bus_in;
          else            m[i].fdata = bus_in;
        end
        if (m[i].k == 3 + w) m[i].busy = 0;
        else                 m[i].k++;
      end else if (fetch_req || mem_req) begin
        bit pick_mem;
`ifdef ARB_ROUND_ROBIN_EN
        pick_mem = (fetch_req && mem_req) ? !m[i].last_mem : mem_req;
`else
        pick_mem = mem_req;
`endif
        m[i].last_mem = pick_mem;
        m[i].busy     = 1;
        m[i].k        = 1;
        m[i].g_mem    = pick_mem;
        if (pick_mem) begin
          m[i].addr = mem_addr;  m[i].rr = mem_rom_ram;  m[i].we = mem_we;  m[i].wdata = mem_wdata;
        end else begin
          m[i].addr = fetch_addr; m[i].rr = fetch_rom_ram; m[i].we = 0;     m[i].wdata = 8'h00;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      logic [7:0] e_bus;
      bit e_rr, e_ad, e_we, e_fa, e_ma;
      int w;
      string p;
      w = wc(i);
      e_bus = 8'h00; e_rr = 0; e_ad = 0; e_we = 0; e_fa = 0; e_ma = 0;
      if (m[i].busy) begin
        if (m[i].k == 1) begin
          e_bus = m[i].addr;
          e_rr  = m[i].rr;
        end else if (m[i].k <= 2 + w) begin
          e_ad = 1;
          e_rr = m[i].rr;
          if (m[i].we) e_bus = m[i].wdata;
          if (m[i].k == 2 + w) e_we = m[i].we;
        end else begin
          e_fa = !m[i].g_mem;
          e_ma = m[i].g_mem;
        end
      end
      exp_fack[i] = e_fa;
      exp_mack[i] = e_ma;
      if (i == 0) begin
        if (e_fa || e_ma) ack_log.push_back(m[0].g_mem);
        if (fetch_ack_o[0] || mem_ack_o[0]) dut_acks0++;
      end
      p = $sformatf("u%0d ", i);
      chk({p, "bus_out"},    32'(bus_out_o[i]),    32'(e_bus));
      chk({p, "rom_ram"},    32'(rom_ram_o[i]),    32'(e_rr));
      chk({p, "addr_data"},  32'(addr_data_o[i]),  32'(e_ad));
      chk({p, "bus_we"},     32'(bus_we_o[i]),     32'(e_we));
      chk({p, "fetch_ack"},  32'(fetch_ack_o[i]),  32'(e_fa));
      chk({p, "mem_ack"},    32'(mem_ack_o[i]),    32'(e_ma));
      chk({p, "fetch_data"}, 32'(fetch_data_o[i]), 32'(m[i].fdata));
      chk({p, "mem_rdata"},  32'(mem_rdata_o[i]),  32'(m[i].mdata));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      string p;
      p = $sformatf("%s u%0d ", tag, i);
      chk({p, "bus_out"},    32'(bus_out_o[i]),    32'h0);
      chk({p, "rom_ram"},    32'(rom_ram_o[i]),    32'h0);
      chk({p, "addr_data"},  32'(addr_data_o[i]),  32'h0);
      chk({p, "bus_we"},     32'(bus_we_o[i]),     32'h0);
      chk({p, "fetch_ack"},  32'(fetch_ack_o[i]),  32'h0);
      chk({p, "mem_ack"},    32'(mem_ack_o[i]),    32'h0);
      chk({p, "fetch_data"}, 32'(fetch_data_o[i]), 32'h0);
      chk({p, "mem_rdata"},  32'(mem_rdata_o[i]),  32'h0);
    end
  endtask

  // Inputs are driven at the falling edge; the model steps with the same values the DUT samples.
  task automatic tick();
    model_advance();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // Runs until instance 0 has produced n_acks acks, within a cycle budget.
  task automatic run_acks(input int n_acks, input int budget, input bit drop_on_ack);
    int start;
    int cyc;
    start = ack_log.size();
    cyc = 0;
    while (ack_log.size() - start < n_acks && cyc < budget) begin
      tick();
      cyc++;
      if (drop_on_ack) begin
        if (exp_fack[0]) fetch_req = 0;
        if (exp_mack[0]) mem_req = 0;
      end
    end
    chk("ack count within budget", 32'(ack_log.size() - start), 32'(n_acks));
  endtask

  function automatic bit next_req(input bit cur, input bit acked);
    if (acked) return ($urandom_range(3) == 0);
    if (!cur)  return ($urandom_range(2) == 0);
    return ($urandom_range(15) != 0);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int saved;
    model_reset();
    #3 reset = 1'b0;
    #1 check_zero("reset");
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // Single fetch on the WAIT_CYCLES=1 instance.
    fetch_req = 1; fetch_addr = 8'h3C; fetch_rom_ram = 0; bus_in = 8'hA5;
    tick();
    chk("fetch N+1 bus_out", 32'(bus_out_o[0]), 32'h3C);
    chk("fetch N+1 addr_data", 32'(addr_data_o[0]), 32'h0);
    tick();
    chk("fetch N+2 addr_data", 32'(addr_data_o[0]), 32'h1);
    tick();
    chk("fetch N+3 addr_data", 32'(addr_data_o[0]), 32'h1);
    tick();
    chk("fetch N+4 fetch_ack", 32'(fetch_ack_o[0]), 32'h1);
    chk("fetch N+4 fetch_data", 32'(fetch_data_o[0]), 32'hA5);
    fetch_req = 0;
    repeat (2) tick();

    // Store to RAM.
    mem_req = 1; mem_we = 1; mem_rom_ram = 1; mem_addr = 8'h10; mem_wdata = 8'h7E;
    tick();
    chk("store addr bus_out", 32'(bus_out_o[0]), 32'h10);
    tick();
    tick();
    chk("store data bus_out", 32'(bus_out_o[0]), 32'h7E);
    chk("store data bus_we", 32'(bus_we_o[0]), 32'h1);
    chk("store data rom_ram", 32'(rom_ram_o[0]), 32'h1);
    tick();
    chk("store mem_ack", 32'(mem_ack_o[0]), 32'h1);
    chk("store mem_rdata kept", 32'(mem_rdata_o[0]), 32'h0);
    mem_req = 0;
    repeat (2) tick();

    // Contention: both requesters raised together, each drops on its own ack.
    base = ack_log.size();
    mem_we = 0; fetch_req = 1; mem_req = 1;
    run_acks(2, 40, 1);
    repeat (3) tick();
`ifdef ARB_ROUND_ROBIN_EN
    chk("contention first grant", 32'(ack_log[base]), 32'h0);
    chk("contention second grant", 32'(ack_log[base + 1]), 32'h1);
`else
    chk("contention first grant", 32'(ack_log[base]), 32'h1);
    chk("contention second grant", 32'(ack_log[base + 1]), 32'h0);
`endif

    // Both requests held continuously for four transactions.
    base = ack_log.size();
    fetch_req = 1; mem_req = 1;
    run_acks(4, 60, 0);
    fetch_req = 0; mem_req = 0;
    repeat (3) tick();
    for (int j = 0; j < 4; j++) begin
`ifdef ARB_ROUND_ROBIN_EN
      chk($sformatf("held grant %0d", j), 32'(ack_log[base + j]), 32'(j % 2));
`else
      chk($sformatf("held grant %0d", j), 32'(ack_log[base + j]), 32'h1);
`endif
    end

    // Zero wait states on instance 1; request dropped right after the grant.
    mem_req = 1; mem_we = 0; mem_addr = 8'h01; bus_in = 8'h5A;
    tick();
    chk("w0 N+1 bus_out", 32'(bus_out_o[1]), 32'h01);
    chk("w0 N+1 addr_data", 32'(addr_data_o[1]), 32'h0);
    mem_req = 0;
    tick();
    chk("w0 N+2 addr_data", 32'(addr_data_o[1]), 32'h1);
    tick();
    chk("w0 N+3 mem_ack", 32'(mem_ack_o[1]), 32'h1);
    chk("w0 N+3 mem_rdata", 32'(mem_rdata_o[1]), 32'h5A);
    tick();
    chk("w1 dropped req N+4 mem_ack", 32'(mem_ack_o[0]), 32'h1);
    repeat (2) tick();

    // Reset in the middle of a load's wait state.
    mem_req = 1; mem_we = 0; mem_addr = 8'hC3;
    tick();
    tick();
    chk("abort in wait addr_data", 32'(addr_data_o[0]), 32'h1);
    #2 reset = 1'b0;
    #1 check_zero("abort");
    model_reset();
    mem_req = 0;
    saved = dut_acks0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (8) tick();
    chk("no ack after abort", 32'(dut_acks0 - saved), 32'h0);

    // Randomized traffic; every input field changes every cycle.
    for (int c = 0; c < 1500; c++) begin
      fetch_addr    = 8'($urandom);
      fetch_rom_ram = 1'($urandom);
      mem_we        = 1'($urandom);
      mem_rom_ram   = 1'($urandom);
      mem_addr      = 8'($urandom);
      mem_wdata     = 8'($urandom);
      bus_in        = 8'($urandom);
      fetch_req     = next_req(fetch_req, exp_fack[0]);
      mem_req       = next_req(mem_req, exp_mack[0]);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Sequences the CPU's shared 8-bit multiplexed external memory bus (rom_ram select, addr_data phase flag, single data_out/data_in pair). Two requesters compete for it:
- the instruction fetcher (fetch port)
- the load/store path (mem port)

The block arbitrates between them and runs each transaction as address phase, optional wait states, then data phase. It returns read data with a one-cycle ack pulse. Sits between the cpu core and the chip pins.

Parameters:
BITS, 8, data/address width
WAIT_CYCLES, 1, wait-state cycles between address and data phase (0..7; 0 skips WAIT)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
fetch_req  input  1  fetch request, level, held until fetch_ack
fetch_rom_ram  input  1  fetch source, 0=ROM 1=RAM
fetch_addr  input  BITS  fetch address
fetch_ack  output  1  one-cycle pulse, fetch_data valid
fetch_data  output  BITS  fetched byte (registered)
mem_req  input  1  load/store request, level, held until mem_ack
mem_we  input  1  1=store 0=load
mem_rom_ram  input  1  target, 0=ROM 1=RAM
mem_addr  input  BITS  load/store address
mem_wdata  input  BITS  store data
mem_ack  output  1  one-cycle pulse, load data valid / store done
mem_rdata  output  BITS  loaded byte (registered)
bus_in  input  BITS  external bus read data
bus_out  output  BITS  external bus drive value
rom_ram  output  1  external ROM/RAM select
addr_data  output  1  0=address phase, 1=data phase
bus_we  output  1  1 during data phase of a store

Behaviour:
- Reset: asynchronous, active-low.
  - State -> IDLE; wait counter 0; grant = none.
  - All outputs 0: fetch_ack, mem_ack, fetch_data, mem_rdata, bus_out, rom_ram, addr_data, bus_we.
- Reset mid-transaction aborts it: no ack is issued and the bus returns to idle values immediately.
- States: IDLE, ADDR, WAIT, DATA, DONE.
  - IDLE: if any req, arbitrate. Latch grant, addr, rom_ram, we and wdata into internal registers. Go to ADDR. Otherwise stay.
  - ADDR (1 cycle): bus_out=latched addr, addr_data=0, rom_ram=latched. Go to WAIT if WAIT_CYCLES>0, else DATA.
  - WAIT (exactly WAIT_CYCLES cycles): addr_data=1; bus_out=wdata if store, else 0. Counter counts down; leave to DATA when it reaches 1.
  - DATA (1 cycle): addr_data=1, bus_we=we. On a load, capture bus_in at the clock edge ending DATA into the granted requester's data register. Go to DONE.
  - DONE (1 cycle): granted requester's ack=1. Bus outputs return to idle values. Go to IDLE.
- Outputs are decoded from registered state and latched fields only; no combinational path from req to bus pins.
- Latency: with req first seen high in IDLE at cycle N, ack is high in cycle N+3+WAIT_CYCLES. Back-to-back throughput is one transaction per 4+WAIT_CYCLES cycles.
- rom_ram holds the latched value from ADDR through DATA.
- fetch_data and mem_rdata hold their value until the next load to the same port.
- Fetch transactions ignore we and are always reads.
- Requester drops req before its ack: the transaction still completes and ack still pulses.
- Requester changes inputs after grant: no effect, since the fields are latched.
- Both reqs high in IDLE: arbitration rule applies (see Optional Feature). The loser stays pending and is granted at the next IDLE.
- A req still high in the DONE cycle is treated as a new request, because requesters deassert on ack.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. A last-grant flop (reset = fetch) gives priority to the requester not granted last. With both reqs held high, grants alternate.
- Undefined: fixed priority, mem over fetch. Fetch is granted only when mem_req=0 in IDLE. No last-grant flop exists.

Decomposition:
- Package cpu_bus_pkg holds:
  - state encoding constants STATE_IDLE..STATE_DONE
  - FETCH_ROM=0 / FETCH_RAM=1
  - BITS
  - grant encoding GRANT_FETCH / GRANT_MEM
- One sub-module, bus_arbiter. It is purely the grant decision: inputs fetch_req, mem_req, enable (state==IDLE), clk and reset for the round-robin flop; output grant_valid and grant_sel. It contains the ARB_ROUND_ROBIN_EN conditional.

Test Plan:
- Reset: assert reset low mid-WAIT of a load -> all outputs 0 immediately; after release, state IDLE and no ack ever pulses for the aborted load.
- Single fetch, WAIT_CYCLES=1: fetch_req=1, fetch_addr=0x3C, rom_ram=0, bus_in=0xA5 during DATA.
  - bus_out=0x3C with addr_data=0 at N+1; addr_data=1 at N+2..N+3.
  - fetch_ack=1 and fetch_data=0xA5 at N+4.
- Store: mem_we=1, mem_rom_ram=1, mem_addr=0x10, mem_wdata=0x7E.
  - ADDR shows bus_out=0x10.
  - DATA shows bus_out=0x7E, bus_we=1, rom_ram=1.
  - mem_ack pulses once; mem_rdata is unchanged.
- Contention, fixed priority (macro off): both reqs high at N -> mem served first, fetch granted at the following IDLE; two acks in order mem, fetch.
- Contention, round-robin (macro on): both reqs re-asserted continuously for 4 transactions -> grants alternate fetch, mem, fetch, mem.
- WAIT_CYCLES=0: load at 0x01 -> ack at N+3, no WAIT state visited; req dropped at N+1 still yields the ack.
